// File: rtl/banked_ram.sv
// Banked byte RAM shared by a read/write CPU port and a read-only DMA port.
// Fixed bank 0 in the lower half, switchable bank in the upper half, one-cycle registered reads.
module banked_ram #(
   parameter int D         = 12,
   parameter int BANKS     = 8,
   parameter int MAX_STALL = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [D:0]   cpu_addr,
   input  logic         cpu_req,
   input  logic         cpu_write,
   input  logic [7:0]   cpu_d_in,
   output logic         cpu_ready,
   output logic [7:0]   cpu_d_out,
   input  logic [D:0]   dma_addr,
   input  logic         dma_req,
   output logic         dma_ready,
   output logic [7:0]   dma_d_out,
   output logic         dma_valid,
   input  logic         bank_write,
   input  logic [7:0]   bank_in,
   output logic [7:0]   bank_out
);

   localparam int BW    = $clog2(BANKS);
   localparam int AW    = D + BW;
   localparam int DEPTH = BANKS << D;
   localparam int SW    = $clog2(MAX_STALL + 1);
   localparam logic [7:0] BANK_MASK = 8'((1 << BW) - 1);

   logic [7:0]    mem_q [DEPTH];

   logic [BW-1:0] bank_q, bank_d;
   logic [SW-1:0] stall_q, stall_d;
   logic [7:0]    cpu_d_out_q, cpu_d_out_d;
   logic [7:0]    dma_d_out_q, dma_d_out_d;
   logic          dma_valid_q, dma_valid_d;

   logic [BW-1:0] eff_bank;
   logic [AW-1:0] cpu_idx, dma_idx, acc_idx;
   logic [7:0]    rd_data;
   logic          cpu_gnt, dma_gnt, stall_max;
   logic          unused_bank_bits;

   // Only the low BW bits of bank_in are stored.
   assign unused_bank_bits = ^bank_in;

   function automatic logic [AW-1:0] map_idx(input logic [D:0] addr, input logic [BW-1:0] eb);
      logic [BW-1:0] b;
      b = addr[D] ? eb : {BW{1'b0}};
      return {b, addr[D-1:0]};
   endfunction

   // Stored bank 0 still selects physical bank 1 so the upper half never aliases bank 0.
   assign eff_bank  = (bank_q == {BW{1'b0}}) ? BW'(1) : bank_q;
   assign cpu_idx   = map_idx(cpu_addr, eff_bank);
   assign dma_idx   = map_idx(dma_addr, eff_bank);
   assign stall_max = (stall_q == SW'(MAX_STALL));

   // DMA has priority until the CPU has waited MAX_STALL cycles; nothing is granted in reset.
   assign cpu_gnt   = !rst && cpu_req && (!dma_req || stall_max);
   assign dma_gnt   = !rst && dma_req && !cpu_gnt;
   assign cpu_ready = !rst && (!cpu_req || cpu_gnt);
   assign dma_ready = !rst && (!dma_req || dma_gnt);

   // Single array access per cycle: the granted port owns the address.
   assign acc_idx = cpu_gnt ? cpu_idx : dma_idx;
   assign rd_data = mem_q[acc_idx];

   always_comb begin
      bank_d      = bank_q;
      stall_d     = '0;
      cpu_d_out_d = cpu_d_out_q;
      dma_d_out_d = dma_d_out_q;
      dma_valid_d = dma_gnt;
      if (bank_write)
         bank_d = bank_in[BW-1:0];
      if (cpu_req && !cpu_gnt)
         stall_d = stall_max ? stall_q : stall_q + SW'(1);
      if (cpu_gnt)
         cpu_d_out_d = rd_data;
      if (dma_gnt)
         dma_d_out_d = rd_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_q      <= '0;
         stall_q     <= '0;
         cpu_d_out_q <= '0;
         dma_d_out_q <= '0;
         dma_valid_q <= 1'b0;
      end else begin
         bank_q      <= bank_d;
         stall_q     <= stall_d;
         cpu_d_out_q <= cpu_d_out_d;
         dma_d_out_q <= dma_d_out_d;
         dma_valid_q <= dma_valid_d;
      end
   end

   // Contents are deliberately not reset; cpu_gnt is already blocked during rst.
   always_ff @(posedge clk) begin
      if (cpu_gnt && cpu_write)
         mem_q[cpu_idx] <= cpu_d_in;
   end

   assign cpu_d_out = cpu_d_out_q;
   assign dma_d_out = dma_d_out_q;
   assign dma_valid = dma_valid_q;
   assign bank_out  = ~BANK_MASK | 8'(bank_q);

endmodule
